// File: rtl/priority_encoder4to2_seq.sv
// priority_encoder4to2_seq
//   Sequential 4-to-2 priority encoder. It latches request bits into a sticky
//   pending register. It grants one pending bit per load, either by fixed
//   priority or by rotating priority. The encoded index is presented through
//   a valid/ready output register.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   capture enable for req (draining is unaffected)
//   req[3:0]   in   level-sampled request bits, multi-hot allowed
//   out_ready  in   consumer accepts out_idx when out_valid && out_ready
//   clr_ovf    in   synchronous clear of overflow (a new overflow wins)
//   out_valid  out  out_idx holds a valid grant
//   out_idx    out  encoded index of the granted request
//   pending    out  pending-request register
//   overflow   out  sticky: a request merged into an already-pending bit
//   busy       out  |pending | out_valid, decoded from registers only
module priority_encoder4to2_seq #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       out_ready,
  input  logic       clr_ovf,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic [3:0] pending,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  logic [N_REQ-1:0] pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             overflow_q, overflow_d;

  logic [IDX_W-1:0] sel_fix;
  logic [IDX_W-1:0] sel_rr;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic             rr_found;
  logic             load;
  logic             grant;
  logic [N_REQ-1:0] clr_mask;
  logic [N_REQ-1:0] req_en;
  logic             ovf_hit;

  // Fixed priority: the highest set index wins (ascending scan, last hit kept).
  always_comb begin
    sel_fix = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pending_q[i]) sel_fix = IDX_W'(i);
    end
  end

  // Rotating priority: scan last_idx-1, last_idx-2, ... wrapping back to last_idx.
  always_comb begin
    sel_rr   = last_idx_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = last_idx_q - IDX_W'(k);
      if (!rr_found && pending_q[cand]) begin
        sel_rr   = cand;
        rr_found = 1'b1;
      end
    end
  end

  assign sel = ROUND_ROBIN ? sel_rr : sel_fix;

  // Grant and pending/overflow next-state.
  always_comb begin
    load     = !out_valid_q || out_ready;
    grant    = load && (|pending_q);
    clr_mask = grant ? (N_REQ'(1) << sel) : '0;
    req_en   = req & {N_REQ{en}};

    // A request landing on the bit being cleared re-pends it without overflow.
    pending_d = (pending_q & ~clr_mask) | req_en;
    ovf_hit   = |(req_en & pending_q & ~clr_mask);

    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (ovf_hit) overflow_d = 1'b1;
  end

  // Output register: reload on an empty or accepted slot, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    last_idx_d  = last_idx_q;
    if (load) begin
      out_valid_d = grant;
      if (grant) begin
        out_idx_d  = sel;
        last_idx_d = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      last_idx_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      last_idx_q  <= last_idx_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign busy      = (|pending_q) | out_valid_q;

endmodule

// File: tb/tb_priority_encoder4to2_seq.sv
// Directed bench for priority_encoder4to2_seq: a fixed-priority instance and
// a rotating-priority instance share the stimulus.
module tb_priority_encoder4to2_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       out_ready;
  logic       clr_ovf;

  logic       f_valid, f_ovf, f_busy;
  logic [1:0] f_idx;
  logic [3:0] f_pend;
  logic       r_valid, r_ovf, r_busy;
  logic [1:0] r_idx;
  logic [3:0] r_pend;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  priority_encoder4to2_seq #(.ROUND_ROBIN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
    .clr_ovf(clr_ovf), .out_valid(f_valid), .out_idx(f_idx),
    .pending(f_pend), .overflow(f_ovf), .busy(f_busy)
  );

  priority_encoder4to2_seq #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
    .clr_ovf(clr_ovf), .out_valid(r_valid), .out_idx(r_idx),
    .pending(r_pend), .overflow(r_ovf), .busy(r_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Fixed-priority instance: valid, idx, pending, overflow.
  task automatic chk_f(input string tag, input logic v, input logic [1:0] i,
                       input logic [3:0] p, input logic o);
    chk({tag, ".valid"}, 32'(f_valid), 32'(v));
    if (v) chk({tag, ".idx"}, 32'(f_idx), 32'(i));
    chk({tag, ".pend"}, 32'(f_pend), 32'(p));
    chk({tag, ".ovf"}, 32'(f_ovf), 32'(o));
  endtask

  logic [1:0] rr_exp [5];

  initial begin
    rst_n = 1'b0; en = 1'b1; req = '0; out_ready = 1'b1; clr_ovf = 1'b0;
    #1;
    chk("rst.valid", 32'(f_valid), 32'd0);
    chk("rst.idx",   32'(f_idx),   32'd0);
    chk("rst.pend",  32'(f_pend),  32'd0);
    chk("rst.ovf",   32'(f_ovf),   32'd0);
    chk("rst.busy",  32'(f_busy),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: pulse 0101, grants 2 then 0, then idle.
    req = 4'b0101; tick(); req = '0;
    chk_f("t1.e1", 1'b0, 2'd0, 4'b0101, 1'b0);
    tick(); chk_f("t1.e2", 1'b1, 2'd2, 4'b0001, 1'b0);
    tick(); chk_f("t1.e3", 1'b1, 2'd0, 4'b0000, 1'b0);
    tick(); chk_f("t1.e4", 1'b0, 2'd0, 4'b0000, 1'b0);
    chk("t1.busy", 32'(f_busy), 32'd0);

    // 2: backpressure with 1111, index 3 held, then 2,1,0.
    out_ready = 1'b0; req = 4'b1111; tick(); req = '0;
    chk_f("t2.cap", 1'b0, 2'd0, 4'b1111, 1'b0);
    tick(); chk_f("t2.s1", 1'b1, 2'd3, 4'b0111, 1'b0);
    tick(); chk_f("t2.s2", 1'b1, 2'd3, 4'b0111, 1'b0);
    tick(); chk_f("t2.s3", 1'b1, 2'd3, 4'b0111, 1'b0);
    out_ready = 1'b1;
    tick(); chk_f("t2.g2", 1'b1, 2'd2, 4'b0011, 1'b0);
    tick(); chk_f("t2.g1", 1'b1, 2'd1, 4'b0001, 1'b0);
    tick(); chk_f("t2.g0", 1'b1, 2'd0, 4'b0000, 1'b0);
    tick(); chk_f("t2.idle", 1'b0, 2'd0, 4'b0000, 1'b0);

    // 3: overflow while the output stage is stalled on index 3.
    out_ready = 1'b0; req = 4'b1000; tick(); req = '0;
    tick(); chk_f("t3.stall", 1'b1, 2'd3, 4'b0000, 1'b0);
    req = 4'b0010; tick();
    chk_f("t3.r1", 1'b1, 2'd3, 4'b0010, 1'b0);
    tick(); req = '0;
    chk_f("t3.r2", 1'b1, 2'd3, 4'b0010, 1'b1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk_f("t3.clr", 1'b1, 2'd3, 4'b0010, 1'b0);
    out_ready = 1'b1;
    tick(); chk_f("t3.g1", 1'b1, 2'd1, 4'b0000, 1'b0);
    tick(); chk_f("t3.idle", 1'b0, 2'd0, 4'b0000, 1'b0);

    // 4: request bit 1 on the same edge it is granted.
    req = 4'b0010; tick();
    chk_f("t4.cap", 1'b0, 2'd0, 4'b0010, 1'b0);
    tick(); req = '0;
    chk_f("t4.coll", 1'b1, 2'd1, 4'b0010, 1'b0);
    tick(); chk_f("t4.regr", 1'b1, 2'd1, 4'b0000, 1'b0);
    tick(); chk_f("t4.idle", 1'b0, 2'd0, 4'b0000, 1'b0);

    // 5: rotating priority with each granted bit refilled on its grant edge.
    do_reset();
    rr_exp[0] = 2'd3; rr_exp[1] = 2'd2; rr_exp[2] = 2'd1;
    rr_exp[3] = 2'd0; rr_exp[4] = 2'd3;
    req = 4'b1111; tick();
    chk("t5.fill", 32'(r_pend), 32'hf);
    for (int g = 0; g < 5; g++) begin
      req = 4'(1) << rr_exp[g];
      tick();
      chk($sformatf("t5.g%0d.valid", g), 32'(r_valid), 32'd1);
      chk($sformatf("t5.g%0d.idx", g),   32'(r_idx),   32'(rr_exp[g]));
      chk($sformatf("t5.g%0d.pend", g),  32'(r_pend),  32'hf);
    end
    chk("t5.ovf", 32'(r_ovf), 32'd0);

    // 5b: en=0 ignores held requests; the backlog drains 2,1,0,3.
    en = 1'b0; req = 4'b1111;
    rr_exp[0] = 2'd2; rr_exp[1] = 2'd1; rr_exp[2] = 2'd0; rr_exp[3] = 2'd3;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("t5b.g%0d.idx", g), 32'(r_idx), 32'(rr_exp[g]));
      chk($sformatf("t5b.g%0d.ovf", g), 32'(r_ovf), 32'd0);
    end
    tick();
    chk("t5b.idle", 32'(r_valid), 32'd0);
    chk("t5b.busy", 32'(r_busy), 32'd0);
    chk("t5b.ovf",  32'(r_ovf),  32'd0);
    en = 1'b1; req = '0;

    // 6: asynchronous reset with index 3 stalled and pending=1010.
    do_reset();
    out_ready = 1'b0; req = 4'b1000; tick();
    req = 4'b1010; tick(); req = '0;
    chk_f("t6.pre", 1'b1, 2'd3, 4'b1010, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst.valid", 32'(f_valid), 32'd0);
    chk("t6.rst.idx",   32'(f_idx),   32'd0);
    chk("t6.rst.pend",  32'(f_pend),  32'd0);
    chk("t6.rst.busy",  32'(f_busy),  32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t6.post%0d.valid", c), 32'(f_valid), 32'd0);
      chk($sformatf("t6.post%0d.busy", c),  32'(f_busy),  32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_encoder4to2_seq.md
# priority_encoder4to2_seq

Sequential 4-to-2 priority encoder: the encode-side counterpart of the team's 2-to-4 decoder. It captures request bits on `req[3:0]` into a sticky pending register. It emits one encoded 2-bit index per grant through a valid/ready output register, and clears each served request bit. It sits between request sources, such as interrupt or event lines, and a consumer that accepts one index at a time. That consumer may drive a 2-to-4 decoder to regenerate a one-hot acknowledge.

## Interface
- `ROUND_ROBIN`, default 0. 0 = fixed priority, bit 3 highest. 1 = rotating priority starting below the last granted index.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset: asynchronous assert, active-low.
- `en`  in  1  capture enable; when 0, `req` is ignored and pending bits keep draining.
- `req`  in  4  request bits, sampled every cycle; multi-hot allowed.
- `out_ready`  in  1  consumer accepts `out_idx` when `out_valid && out_ready`.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `out_valid`  out  1  `out_idx` holds a valid encoded request.
- `out_idx`  out  2  encoded index of the granted request.
- `pending`  out  4  pending-request register (status).
- `overflow`  out  1  sticky flag: a request was merged into an already-pending bit.
- `busy`  out  1  `|pending | out_valid`, combinational from registers.

## Operation
- Reset (`rst_n`=0, async) forces these values:
  - `pending`=0, `out_valid`=0, `out_idx`=0, `overflow`=0.
  - internal `last_idx`=0.
- Load condition `load = !out_valid || out_ready`.
- Selection `sel`:
  - Taken from the registered `pending` only; same-cycle `req` is never selected.
  - Fixed mode: highest set index of `pending`.
  - RR mode: search indices `last_idx-1, last_idx-2, …, last_idx` (mod 4), taking the first set bit. After reset the search order is therefore 3,2,1,0.
- On a clock edge with `load`:
  - If `pending`≠0: `out_idx`←`sel`, `out_valid`←1, `last_idx`←`sel`, and bit `sel` is cleared in `pending`.
  - Otherwise `out_valid`←0 and `out_idx` holds its value.
- When `out_valid && !out_ready`: `out_idx`, `out_valid` and `last_idx` hold; `pending` only accumulates.
- Pending update: `pending ← (pending & ~clr_mask) | (req & {4{en}})`.
  - `clr_mask` is the one-hot of `sel` when a load with nonzero `pending` occurs, else 0.
  - Set wins: a `req` bit arriving on the same edge that clears it leaves the bit pending.
- Overflow:
  - `overflow`←1 when any bit of `req & {4{en}} & pending & ~clr_mask` is set.
  - Sticky until `clr_ovf`.
  - If `clr_ovf` and a new overflow condition occur in the same cycle, set wins.
- Request bits are level-sampled. A `req` bit held high for k cycles re-pends every cycle and flags overflow from the second cycle, unless that bit is cleared the same cycle. Sources drive single-cycle pulses.

## Timing
- Latency: a `req` pulse sampled at edge N is in `pending` after N. With an idle output stage it appears on `out_valid`/`out_idx` after edge N+1, i.e. 2 cycles.
- Throughput: one grant per cycle while `out_ready`=1 and `pending`≠0.
- Output timing:
  - `out_valid` and `out_idx` are registered outputs.
  - `busy` and `pending` are register-derived with no input-to-output combinational path.
  - `out_ready` affects only next-state logic.
- Reset mid-operation: everything clears asynchronously and all queued requests are lost. The first capture is on the first rising edge after `rst_n` deasserts.
- `en` only gates capture; in-flight and pending requests drain regardless of `en`.

## Test plan
1. Reset, then `req`=4'b0101 for 1 cycle with `out_ready`=1 and fixed mode. Expected:
   - `out_idx`=2 appears 2 cycles later, then `out_idx`=0 on the next cycle.
   - `out_valid` drops on the following cycle and `busy` goes 0.
2. Backpressure, fixed mode: `req`=4'b1111 with `out_ready`=0 for 3 cycles. Expected:
   - `out_idx`=3 holds stable with `out_valid`=1.
   - Once `out_ready`=1: indices 2, 1, 0 follow on consecutive cycles.
3. Overflow: `req`=4'b0010 on two consecutive cycles with `out_ready`=0. Expected:
   - `overflow`=1 after the second edge, with a single pending bit.
   - `clr_ovf` pulse returns `overflow`=0.
4. Set-wins collision: with bit 1 being granted, pulse `req`=4'b0010 on the same edge. Expected:
   - `pending[1]` stays 1 and `overflow` stays 0.
   - `out_idx`=1 is granted again.
5. RR mode: keep `pending`=4'b1111, refilling `req` each grant, with `out_ready`=1. Expected:
   - Grant sequence 3,2,1,0,3.
   - Repeat the test with `en`=0: requests are ignored and `overflow` stays 0.
6. Reset mid-stream: assert `rst_n`=0 while `out_valid`=1 and `pending`=4'b1010. Expected:
   - All outputs go 0 immediately, without waiting for a clock.
   - After release, no stale index is emitted.
